axis_slave_buf: RTL

- AXI-Stream slave receive stage. It consumes the stream produced by the fabric-side AXI-Stream master and buffers beats in a small first-word-fall-through FIFO.
- It presents buffered beats to a backend consumer on a valid/ready interface, which mirrors the backend interface of the master stage.
- It decouples stream back-pressure from backend latency and counts accepted beats for status.

---
 rtl/axis_slave_buf.sv | 99 +++++++++
 1 files changed

// File: rtl/axis_slave_buf.sv
// AXI-Stream slave receive stage: buffers accepted beats in a first-word-fall-through
// FIFO toward a valid/ready backend and keeps a saturating accepted-beat counter.
module axis_slave_buf #(
  parameter int DEPTH_LOG2 = 2,
  parameter int DATA_W     = 32,
  parameter int USER_W     = 2
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  axis_tvalid,
  input  logic [DATA_W-1:0]     axis_tdata,
  input  logic [DATA_W/8-1:0]   axis_tstrb,
  input  logic [DATA_W/8-1:0]   axis_tkeep,
  input  logic                  axis_tlast,
  input  logic [USER_W-1:0]     axis_tuser,
  output logic                  axis_tready,
  output logic [DATA_W-1:0]     bk_data,
  output logic [USER_W-1:0]     bk_user,
  output logic                  bk_last,
  output logic                  bk_valid,
  input  logic                  bk_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           rx_beats
);

  localparam int DEPTH   = 32'sd1 << DEPTH_LOG2;
  localparam int ENTRY_W = DATA_W + USER_W + 32'sd1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = CNT_ONE[DEPTH_LOG2-1:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

  logic [ENTRY_W-1:0]    mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  ready_r;
  logic [15:0]           rx_beats_r;
  logic                  push_s;
  logic                  pop_s;
  logic [ENTRY_W-1:0]    head_s;
  logic                  unused_s;

  // Handshake decode and next occupancy
  always_comb begin
    push_s      = axis_tvalid & ready_r;
    pop_s       = bk_valid & bk_ready;
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Beat storage, cleared on reset so the head reads zero when empty
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {ENTRY_W{1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {axis_tlast, axis_tuser, axis_tdata};
    end
  end

  // Pointers, occupancy, registered ready and beat counter
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      ready_r    <= 1'b0;
      rx_beats_r <= 16'h0000;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      count_r  <= count_nxt_s;
      // ready only looks at next occupancy, so full can never be overrun
      ready_r  <= (count_nxt_s < CNT_FULL);
      if (push_s && (rx_beats_r != 16'hFFFF)) begin
        rx_beats_r <= rx_beats_r + 16'h0001;
      end else begin
        rx_beats_r <= rx_beats_r;
      end
    end
  end

  assign head_s      = mem_r[rd_ptr_r];
  assign bk_data     = head_s[DATA_W-1:0];
  assign bk_user     = head_s[DATA_W +: USER_W];
  assign bk_last     = head_s[ENTRY_W-1];
  assign bk_valid    = (count_r != CNT_ZERO);
  assign axis_tready = ready_r;
  assign fifo_level  = count_r;
  assign rx_beats    = rx_beats_r;
  assign unused_s    = ^{axis_tstrb, axis_tkeep};

endmodule
